// File: rtl/interboard_tx_packer.sv
// Inter-board transmit packer: queues ctrl_* messages and ships each as a nibble frame over a 4-phase req/ack link.
// Optional INTERBOARD_TX_PARITY_EN appends an XOR parity nibble to every frame.
module interboard_tx_packer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       transmit,
  input  logic       ctrl_en,
  input  logic [3:0] ctrl_msg_type,
  input  logic       ctrl_move_dir,
  input  logic [4:0] ctrl_block_x,
  input  logic [2:0] ctrl_block_y,
  input  logic [5:0] ctrl_card,
  input  logic [2:0] ctrl_sel_len,
  input  logic       tx_ack,
  output logic       tx_req,
  output logic [3:0] tx_data,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic       timeout_err
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef INTERBOARD_TX_PARITY_EN
  localparam int unsigned NIBBLES = 7;
`else
  localparam int unsigned NIBBLES = 6;
`endif
  localparam int unsigned FW = 4 * NIBBLES;

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [21:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_meta_q, ack_s_q;
  logic [FW-1:0]   shift_q, shift_d, frame_load;
  logic [2:0]      nib_q, nib_d;
  logic [TW-1:0]   tcnt_q, tcnt_d, tcnt_inc;
  logic [1:0]      seq_q, seq_d;
  logic            tx_req_q, tx_req_d;
  logic [3:0]      tx_data_q, tx_data_d;
  logic            busy_q, busy_d, full_q, full_d, ovf_q, ovf_d, terr_q, terr_d;
  logic            push, push_ok, pop, timeout_hit;
  logic [21:0]     entry_in;
  logic [23:0]     word;

  assign entry_in = {ctrl_msg_type, ctrl_move_dir, ctrl_block_x, ctrl_block_y,
                     ctrl_card, ctrl_sel_len};
  assign push     = ctrl_en & transmit;
  assign word     = {seq_q, mem_q[rd_ptr_q]};
  assign tcnt_inc = tcnt_q + TW'(1);
  assign timeout_hit = (tcnt_inc == TW'(TIMEOUT_CYCLES));

`ifdef INTERBOARD_TX_PARITY_EN
  logic [3:0] parity;
  always_comb begin
    parity = '0;
    for (int unsigned i = 0; i < 6; i++) parity = parity ^ word[4*i +: 4];
    frame_load = {word, parity};
  end
`else
  always_comb frame_load = word;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    nib_d   = nib_q;
    tcnt_d  = '0;
    seq_d   = seq_q;
    terr_d  = terr_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0 && !ack_s_q) begin
          pop     = 1'b1;
          shift_d = frame_load;
          nib_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        tcnt_d = tcnt_inc;
        if (timeout_hit) begin
          terr_d  = 1'b1;
          tcnt_d  = '0;
          state_d = IDLE;
        end else if (ack_s_q) begin
          tcnt_d  = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        tcnt_d = tcnt_inc;
        if (timeout_hit) begin
          terr_d  = 1'b1;
          tcnt_d  = '0;
          state_d = IDLE;
        end else if (!ack_s_q) begin
          tcnt_d = '0;
          if (nib_q == 3'(NIBBLES - 1)) begin
            seq_d   = seq_q + 2'd1;
            state_d = IDLE;
          end else begin
            shift_d = shift_q << 4;
            nib_d   = nib_q + 3'd1;
            state_d = DRIVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    push_ok  = push & ((cnt_q != CW'(FIFO_DEPTH)) | pop);
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d    = ovf_q | (push & ~push_ok);

    tx_req_d  = (state_q == DRIVE);
    tx_data_d = shift_q[FW-1 -: 4];
    busy_d    = (cnt_d != '0) || (state_d != IDLE);
    full_d    = (cnt_d == CW'(FIFO_DEPTH));

    if (interboard_rst) begin
      push_ok  = 1'b0;
      state_d  = IDLE;
      tcnt_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      terr_d   = 1'b0;
      tx_req_d = 1'b0;
      busy_d   = 1'b0;
      full_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= entry_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      shift_q    <= '0;
      nib_q      <= '0;
      tcnt_q     <= '0;
      seq_q      <= '0;
      tx_req_q   <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ack_meta_q <= tx_ack;
      ack_s_q    <= ack_meta_q;
      shift_q    <= shift_d;
      nib_q      <= nib_d;
      tcnt_q     <= tcnt_d;
      seq_q      <= seq_d;
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      terr_q     <= terr_d;
    end
  end

  assign tx_req      = tx_req_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign fifo_full   = full_q;
  assign overflow    = ovf_q;
  assign timeout_err = terr_q;

endmodule
